// File: rtl/fp32_iterative_divider.sv
// ---------------------------------------------------------------------------
// fp32_iterative_divider
//
// Sequential IEEE-754 single-precision divider (quotient = a / b).
// The mantissa quotient is produced by a restoring radix-2 divider, one bit
// per clock, 25 bits in total. The result is truncated (round toward zero).
// Denormal operands are flushed to zero. Special operands use the same
// zero/inf/NaN encodings as the FP multiplier.
//
// Handshake (start/busy/done):
//   A request is accepted on a rising edge where start=1 and the FSM is IDLE.
//   That edge is the accepting edge. a and b are captured on it and may
//   change afterwards. busy is high from the accepting edge until done
//   falls. start is ignored while busy is high. done is a one-cycle pulse.
//   quotient and the flags are valid while done is high. They hold until
//   the next result is loaded or reset is applied.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous, active-high reset
//   start      in   request, sampled only in IDLE
//   a, b       in   dividend / divisor (FP32)
//   quotient   out  registered result
//   done       out  one-cycle result-valid pulse
//   busy       out  operation in flight
//   nan_f      out  result is NaN
//   inf_f      out  result is infinity
//   zero_f     out  result is zero
//   dz_f       out  divide by zero (always together with inf_f)
//   fsm_state  out  current FSM state (IDLE=0, DIV=1, NORM=2, DONE=3)
// ---------------------------------------------------------------------------
module fp32_iterative_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] quotient,
  output logic        done,
  output logic        busy,
  output logic        nan_f,
  output logic        inf_f,
  output logic        zero_f,
  output logic        dz_f,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;
  logic               sign;
  logic [24:0]        rem;
  logic [23:0]        dvs;
  logic [24:0]        q;
  logic signed [9:0]  ex;
  logic [4:0]         cnt;

  // A special-case result is captured at the accepting edge and published
  // from DONE one edge later.
  logic [31:0]        spec_q;
  logic               spec_nan;
  logic               spec_inf;
  logic               spec_zero;
  logic               spec_dz;

  // ---------------- Operand classification ----------------
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_zero, a_inf, a_nan;
  logic        b_zero, b_inf, b_nan;
  logic        in_sign;
  logic        is_nan, is_inf, is_zero, is_special;

  assign ea      = a[30:23];
  assign eb      = b[30:23];
  assign fa      = a[22:0];
  assign fb      = b[22:0];
  assign in_sign = a[31] ^ b[31];

  assign a_zero  = (ea == 8'h00);
  assign b_zero  = (eb == 8'h00);
  assign a_inf   = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf   = (eb == 8'hFF) && (fb == 23'd0);
  assign a_nan   = (ea == 8'hFF) && (fa != 23'd0);
  assign b_nan   = (eb == 8'hFF) && (fb != 23'd0);

  // Priority: NaN > Inf > Zero.
  assign is_nan     = a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf);
  assign is_inf     = !is_nan && (a_inf || b_zero);
  assign is_zero    = !is_nan && !is_inf && (a_zero || b_inf);
  assign is_special = is_nan || is_inf || is_zero;

  // Biased quotient exponent: ea - eb + 127 lies in [-126, 380], so 10 bits
  // signed covers it without wrap.
  logic [9:0] ex_init;
  assign ex_init = {2'b00, ea} - {2'b00, eb} + 10'd127;

  // ---------------- Divider step ----------------
  logic        rem_ge;
  logic [24:0] rem_sub;

  assign rem_ge  = (rem >= {1'b0, dvs});
  assign rem_sub = rem - {1'b0, dvs};

  // ---------------- Normalisation ----------------
  // The mantissa ratio is in (0.5, 2), so either q[24] or q[23] is the
  // leading one.
  logic signed [9:0] exp_n;
  logic [22:0]       frac_n;

  assign exp_n  = q[24] ? ex : (ex - 10'sd1);
  assign frac_n = q[24] ? q[23:1] : q[22:0];

  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      quotient  <= 32'd0;
      done      <= 1'b0;
      busy      <= 1'b0;
      nan_f     <= 1'b0;
      inf_f     <= 1'b0;
      zero_f    <= 1'b0;
      dz_f      <= 1'b0;
      sign      <= 1'b0;
      rem       <= 25'd0;
      dvs       <= 24'd0;
      q         <= 25'd0;
      ex        <= 10'sd0;
      cnt       <= 5'd0;
      spec_q    <= 32'd0;
      spec_nan  <= 1'b0;
      spec_inf  <= 1'b0;
      spec_zero <= 1'b0;
      spec_dz   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            sign <= in_sign;
            if (is_special) begin
              spec_nan  <= is_nan;
              spec_inf  <= is_inf;
              spec_zero <= is_zero;
              spec_dz   <= is_inf && b_zero;
              if (is_nan)
                spec_q <= {in_sign, 8'hFF, 23'h000001};
              else if (is_inf)
                spec_q <= {in_sign, 8'hFF, 23'h000000};
              else
                spec_q <= {in_sign, 31'd0};
              state <= DONE;
            end else begin
              rem   <= {2'b01, fa};
              dvs   <= {1'b1, fb};
              q     <= 25'd0;
              ex    <= $signed(ex_init);
              cnt   <= 5'd0;
              state <= DIV;
            end
          end
        end

        DIV: begin
          if (rem_ge) begin
            q   <= {q[23:0], 1'b1};
            rem <= {rem_sub[23:0], 1'b0};
          end else begin
            q   <= {q[23:0], 1'b0};
            rem <= {rem[23:0], 1'b0};
          end
          if (cnt == 5'd24) begin
            cnt   <= 5'd0;
            state <= NORM;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end

        NORM: begin
          nan_f <= 1'b0;
          dz_f  <= 1'b0;
          if (exp_n >= 10'sd255) begin
            quotient <= {sign, 8'hFF, 23'd0};
            inf_f    <= 1'b1;
            zero_f   <= 1'b0;
          end else if (exp_n <= 10'sd0) begin
            quotient <= {sign, 31'd0};
            inf_f    <= 1'b0;
            zero_f   <= 1'b1;
          end else begin
            quotient <= {sign, exp_n[7:0], frac_n};
            inf_f    <= 1'b0;
            zero_f   <= 1'b0;
          end
          done  <= 1'b1;
          state <= DONE;
        end

        DONE: begin
          if (done) begin
            // Pulse has been visible for one cycle: finish the operation.
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            // Arrived straight from IDLE with a special-case result.
            quotient <= spec_q;
            nan_f    <= spec_nan;
            inf_f    <= spec_inf;
            zero_f   <= spec_zero;
            dz_f     <= spec_dz;
            done     <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fp32_iterative_divider.md
# fp32_iterative_divider

Sequential IEEE-754 single-precision divider, the counterpart to the pipelined FP multiplier in the floating-point datapath. Computes quotient = a / b with a restoring radix-2 mantissa divider under a start/busy/done handshake. Classifies special operands with the same zero/inf/NaN conventions as the multiplier, so both units produce identical special encodings. One division in flight at a time.

## Interface
- No parameters; format fixed at FP32 (1 sign, 8 exponent, 23 fraction bits).
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a  in  32  dividend, sampled on the accepting edge.
- b  in  32  divisor, sampled on the accepting edge.
- quotient  out  32  result, registered; holds until the next result or reset.
- done  out  1  one-cycle pulse; quotient and flags are valid in that cycle.
- busy  out  1  high from the accepting edge until done deasserts.
- nan_f, inf_f, zero_f, dz_f  out  1 each  result-class flags, registered alongside quotient.

## Operation
- **States:** IDLE, DIV, NORM, DONE.
- **Reset:** state=IDLE. quotient=0, done=0, busy=0, all flags=0, iteration counter=0.
- **IDLE**
  - On start=1: latch sign = a[31]^b[31], classify operands, assert busy.
  - Special case -> DONE directly. Otherwise -> DIV.
- **Operand classes**
  - Zero: exponent=0. Denormals are flushed to zero.
  - Inf: exponent=FF, fraction=0.
  - NaN: exponent=FF, fraction≠0.
- **Special-case priority, highest first:**
  - NaN: either input NaN, 0/0, or inf/inf -> {sign, 8'hFF, 23'h000001}, nan_f=1.
  - Inf: a inf, or b zero with a nonzero -> {sign, 8'hFF, 23'h0}, inf_f=1. dz_f=1 when b is zero.
  - Zero: a zero or b inf -> {sign, 31'b0}, zero_f=1.
- **DIV, 25 iterations** (counter 0..24)
  - Init: rem = {1, a[22:0]}, div = {1, b[22:0]}, both 24 bits. Biased exponent ex = ea - eb + 127, held as 10-bit signed.
  - Each cycle: if rem >= div, shift in q bit 1 and rem = (rem - div) << 1; else shift in 0 and rem = rem << 1.
  - rem is 25 bits wide.
  - After iteration 24 -> NORM.
- **NORM**
  - If q[24]=1: frac = q[23:1], exp = ex.
  - Else: frac = q[22:0], exp = ex - 1.
  - Rounding is truncation (round toward zero); the remainder is discarded.
  - If exp >= 255: inf result, inf_f=1.
  - If exp <= 0: signed zero, zero_f=1.
  - Otherwise: {sign, exp[7:0], frac}.
  - Load quotient and flags -> DONE.
- **DONE**
  - done=1 for exactly this cycle, then -> IDLE.
  - busy drops on the same edge.

## Timing
- Accepting edge E0 is the edge where start=1 in IDLE.
- Normal path: state is DIV for E1..E25 and NORM at E25. Quotient is loaded at E26, done is high E26–E27, and busy is high E0–E27.
- Special path: quotient is loaded at E0+1 and done is high for one cycle after that edge.
- start while busy=1 (including the DONE cycle) is ignored. A new request is accepted on the first IDLE cycle.
- a and b may change freely after E0.
- rst overrides everything, including mid-DIV. The operation is aborted with no done pulse, and outputs return to reset values on the next edge.
- Flags are mutually exclusive except dz_f, which always accompanies inf_f. Flags are cleared when a new result is loaded.

## Test plan
- 6.0/2.0 (0x40C00000 / 0x40000000) -> quotient 0x40400000, done exactly 26 cycles after E0, no flags.
- 1.0/3.0 (0x3F800000 / 0x40400000) -> 0x3EAAAAAA (truncated).
- Sign check: -1.0/4.0 (0xBF800000 / 0x40800000) -> 0xBE800000.
- -1.0/0 (0xBF800000 / 0x00000000) -> 0xFF800000, inf_f=1 and dz_f=1, done one cycle after E0.
- Special encodings:
  - 0/0 -> 0x7F800001, nan_f=1.
  - inf/inf (0x7F800000 / 0x7F800000) -> 0x7F800001, nan_f=1.
  - 5.0/inf -> 0x00000000, zero_f=1.
- Range and control:
  - 0x7F000000 / 0x00800000 -> 0x7F800000, inf_f=1.
  - start pulsed at cycle 5 of a divide is ignored.
  - rst at cycle 10 -> busy=0, no done pulse, quotient=0.
